fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer end of the PC register's interface: takes the current PC, issues in-order instruction-memory requests, and buffers returned instructions with their PCs for decode.
- Drives the stall input back to the PC register so the PC advances only when a request is accepted.
- Flushes all pending and in-flight fetches on a redirect, which is the same cycle the PC register loads its next-PC value.

Parameters:
DEPTH, 4, queue entries and maximum outstanding requests (power of 2, >=2)
XLEN, 32, address/instruction width

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
io_pc  input  XLEN  current PC from PC register
io_redirect  input  1  redirect this cycle (tied to PC register next-PC enable)
io_stall_en  output  1  hold PC this cycle
io_imem_req_valid  output  1  fetch request valid
io_imem_req_ready  input  1  memory accepts request
io_imem_req_addr  output  XLEN  fetch address (= io_pc)
io_imem_resp_valid  input  1  response valid; in order; no backpressure
io_imem_resp_data  input  XLEN  instruction word
io_inst_valid  output  1  instruction available to decode
io_inst_ready  input  1  decode accepts
io_inst_data  output  XLEN  instruction at head
io_inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Storage: DEPTH entries {pc, data, filled}.
- Pointers:
  - head: dequeue pointer.
  - fill: oldest entry awaiting a response.
  - tail: allocation pointer.
  - Each pointer is log2(DEPTH)+1 bits and wraps naturally.
  - occ = tail-head.
- drop_cnt, log2(DEPTH)+1 bits: number of in-flight responses still to discard.
- Requests:
  - io_imem_req_valid = !io_redirect && (occ + drop_cnt < DEPTH).
  - On fire (valid&ready): entry[tail] gets pc=io_pc, filled=0; tail++.
- Stall:
  - io_stall_en = !(io_imem_req_valid && io_imem_req_ready), i.e. the PC holds unless a request fires.
  - In a redirect cycle the value is don't-care because the PC register prioritises the load.
- Responses, checked in this order when io_imem_resp_valid=1:
  - if drop_cnt>0: discard and decrement drop_cnt;
  - else if fill!=tail: entry[fill].data=resp, filled=1, fill++;
  - else ignore (spurious).
- Dequeue:
  - io_inst_valid = entry[head].filled && !io_redirect.
  - On valid&ready: head++.
  - io_inst_data and io_inst_pc come from entry[head].
- Redirect (highest priority):
  - head=fill=tail=0 and all filled bits cleared.
  - No request, dequeue, or fill in that cycle.
  - drop_cnt_next = drop_cnt + (tail-fill) - (resp_valid ? 1 : 0).
  - A response in the redirect cycle belongs to the old stream.
- Invariant: occ + drop_cnt <= DEPTH, so outstanding memory requests never exceed DEPTH.
- Full: occ==DEPTH, so req_valid=0 and stall_en=1. Dequeue and request may occur in the same cycle only if occ<DEPTH before that cycle (no same-cycle slot reuse).
- Empty: inst_valid=0.
- Latency: response to inst_valid is 1 cycle (registered); minimum request to dequeue is memory latency + 1.
- Reset:
  - All pointers and drop_cnt are 0; filled bits are cleared.
  - Output values: inst_valid=0, req_valid=1, stall_en=!io_imem_req_ready.
  - Reset mid-operation abandons all state. The memory side is reset by the same signal, so stale responses are not expected; any that arrive are ignored as spurious.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - If the queue holds no filled entry at head, head==fill, resp_valid=1, drop_cnt==0 and there is no redirect, then io_inst_valid=1 that cycle with io_inst_data=io_imem_resp_data and io_inst_pc=entry[head].pc.
  - If io_inst_ready=1 as well, head and fill both advance and nothing is stored; otherwise the word is written to the entry as normal.
- FETCH_BYPASS_EN undefined: strictly registered, 1-cycle response-to-valid latency.

Test Plan:
- Streaming, PC starts 0x0, memory ready always, 1-cycle response, decode ready -> io_inst_pc sequence 0x0,0x4,0x8,... with no gaps after fill-up; stall_en=0 steady state.
- Decode ready=0, DEPTH=4 -> exactly 4 requests accepted (0x0..0xC), then req_valid=0, stall_en=1, PC held at 0x10; ready=1 resumes with 0x10 after one dequeue.
- Memory req_ready=0 for 3 cycles -> stall_en=1 for those 3 cycles, PC stays 0x8, no entry allocated.
- Redirect to 0x100 with 2 requests in flight (3-cycle memory) -> next 2 responses discarded (drop_cnt 2->0); first decoded instruction has pc 0x100; no old-PC instruction is dequeued after the redirect cycle.
- Redirect in the same cycle as resp_valid and inst_valid -> no dequeue that cycle, response counted against drop, queue empty next cycle.
- FETCH_BYPASS_EN, empty queue, response arrives with ready=1 -> inst_valid high in the response cycle with data equal to resp_data; without the macro it goes high one cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle: PC register, instruction-memory and decode handshakes.
// master = environment (PC register, memory, decode); slave = fetch_queue.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] io_pc;
  logic            io_redirect;
  logic            io_stall_en;
  logic            io_imem_req_valid;
  logic            io_imem_req_ready;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid;
  logic [XLEN-1:0] io_imem_resp_data;
  logic            io_inst_valid;
  logic            io_inst_ready;
  logic [XLEN-1:0] io_inst_data;
  logic [XLEN-1:0] io_inst_pc;

  modport master (
    output io_pc, io_redirect, io_imem_req_ready, io_imem_resp_valid,
           io_imem_resp_data, io_inst_ready,
    input  io_stall_en, io_imem_req_valid, io_imem_req_addr, io_inst_valid,
           io_inst_data, io_inst_pc
  );

  modport slave (
    input  io_pc, io_redirect, io_imem_req_ready, io_imem_resp_valid,
           io_imem_resp_data, io_inst_ready,
    output io_stall_en, io_imem_req_valid, io_imem_req_addr, io_inst_valid,
           io_inst_data, io_inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the PC register, instruction memory and decode.
// Optional macro FETCH_BYPASS_EN: forward a response straight to decode when the
// queue head is the entry being filled (zero-cycle response-to-valid).
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.slave io
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  ptr_t head, fill, tail, drop_cnt;
  ptr_t head_n, fill_n, tail_n, drop_n;
  ptr_t occ, in_flight, drop_sum;

  logic [AW-1:0] head_idx, fill_idx, tail_idx;
  logic          room, req_valid, req_fire;
  logic          resp_drop, resp_take, byp, inst_valid, deq, store;

  assign head_idx = head[AW-1:0];
  assign fill_idx = fill[AW-1:0];
  assign tail_idx = tail[AW-1:0];

  // Handshake decode: request admission, response routing, dequeue.
  always_comb begin
    occ       = tail - head;
    in_flight = tail - fill;
    room      = (({1'b0, occ} + {1'b0, drop_cnt}) < (PW + 1)'(DEPTH));
    req_valid = !io.io_redirect && room;
    req_fire  = req_valid && io.io_imem_req_ready;
    resp_drop = io.io_imem_resp_valid && (drop_cnt != '0);
    resp_take = io.io_imem_resp_valid && (drop_cnt == '0) && (fill != tail) && !io.io_redirect;
`ifdef FETCH_BYPASS_EN
    byp       = resp_take && !filled[head_idx] && (head == fill);
`else
    byp       = 1'b0;
`endif
    inst_valid = (filled[head_idx] || byp) && !io.io_redirect;
    deq        = inst_valid && io.io_inst_ready;
    store      = resp_take && !(byp && io.io_inst_ready);
  end

  // Next pointer / discard-count values; a redirect restarts the queue and
  // turns every unanswered request (minus a response arriving now) into a drop.
  always_comb begin
    head_n   = head + PW'(deq);
    fill_n   = fill + PW'(resp_take);
    tail_n   = tail + PW'(req_fire);
    drop_n   = drop_cnt - PW'(resp_drop);
    drop_sum = drop_cnt + in_flight;
    if (io.io_redirect) begin
      head_n = '0;
      fill_n = '0;
      tail_n = '0;
      drop_n = drop_sum - PW'(io.io_imem_resp_valid && (drop_sum != '0));
    end
  end

  // Pointer, drop counter and filled-bit state.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else begin
      head     <= head_n;
      fill     <= fill_n;
      tail     <= tail_n;
      drop_cnt <= drop_n;
      if (io.io_redirect) begin
        filled <= '0;
      end else begin
        if (req_fire) filled[tail_idx] <= 1'b0;
        if (store)    filled[fill_idx] <= 1'b1;
        if (deq && !byp) filled[head_idx] <= 1'b0;
      end
    end
  end

  // Entry payload storage; validity is tracked by the filled bits only.
  always_ff @(posedge clock) begin
    if (!reset && !io.io_redirect) begin
      if (req_fire) pc_mem[tail_idx]   <= io.io_pc;
      if (store)    data_mem[fill_idx] <= io.io_imem_resp_data;
    end
  end

  assign io.io_imem_req_valid = req_valid;
  assign io.io_imem_req_addr  = io.io_pc;
  assign io.io_stall_en       = !req_fire;
  assign io.io_inst_valid     = inst_valid;
  assign io.io_inst_data      = byp ? io.io_imem_resp_data : data_mem[head_idx];
  assign io.io_inst_pc        = pc_mem[head_idx];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: models the PC register, an in-order fixed-latency
// instruction memory and a decode stage around the DUT.
module tb_fetch_queue;
  localparam int unsigned XLEN = 32;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_queue_if #(.XLEN(XLEN)) f ();
  fetch_queue #(.DEPTH(4), .XLEN(XLEN)) dut (.clock(clock), .reset(reset), .io(f));

  int n_cmp = 0;
  int n_err = 0;

  // Environment model state
  int          cyc;
  logic [31:0] pc;
  bit          req_rdy, dec_rdy, redir, spur;
  logic [31:0] redir_tgt;
  int          lat;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_data[$];
  int          dq_cyc[$];
  int          n_fire, n_stall, max_infl;
  logic [31:0] last_fire;
  bit          o_req_valid, o_inst_valid, o_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  task automatic drive_idle();
    f.io_pc = 32'h0;
    f.io_redirect = 1'b0;
    f.io_imem_req_ready = 1'b0;
    f.io_imem_resp_valid = 1'b0;
    f.io_imem_resp_data = 32'h0;
    f.io_inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clock); #1;
    @(posedge clock); #1;
    mq_addr.delete(); mq_due.delete();
    dq_pc.delete(); dq_data.delete(); dq_cyc.delete();
    pc = 32'h0; cyc = 0; n_fire = 0; n_stall = 0; max_infl = 0; last_fire = 32'hx;
    req_rdy = 1'b1; dec_rdy = 1'b1; redir = 1'b0; spur = 1'b0; lat = 1;
    reset = 1'b0;
  endtask

  // One clock of the surrounding system; samples DUT outputs mid-cycle.
  task automatic cycle();
    f.io_pc = pc;
    f.io_redirect = redir;
    f.io_imem_req_ready = req_rdy;
    f.io_inst_ready = dec_rdy;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      f.io_imem_resp_valid = 1'b1;
      f.io_imem_resp_data = word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else if (spur) begin
      f.io_imem_resp_valid = 1'b1;
      f.io_imem_resp_data = 32'hDEAD_BEEF;
    end else begin
      f.io_imem_resp_valid = 1'b0;
      f.io_imem_resp_data = 32'h0;
    end
    #1;
    o_req_valid  = f.io_imem_req_valid;
    o_inst_valid = f.io_inst_valid;
    o_stall      = f.io_stall_en;
    if (f.io_imem_req_valid && f.io_imem_req_ready) begin
      mq_addr.push_back(f.io_imem_req_addr);
      mq_due.push_back(cyc + lat);
      n_fire++;
      last_fire = f.io_imem_req_addr;
    end
    if (mq_addr.size() > max_infl) max_infl = mq_addr.size();
    if (f.io_stall_en) n_stall++;
    if (f.io_inst_valid && f.io_inst_ready) begin
      dq_pc.push_back(f.io_inst_pc);
      dq_data.push_back(f.io_inst_data);
      dq_cyc.push_back(cyc);
    end
    @(posedge clock); #1;
    cyc++;
    if (redir) pc = redir_tgt;
    else if (!o_stall) pc = pc + 32'd4;
    redir = 1'b0;
    spur = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int old_cnt;
    drive_idle();
    @(posedge clock); #1;
    @(posedge clock); #1;
    // Reset-state outputs
    f.io_imem_req_ready = 1'b1; #1;
    check("rst_req_valid", 32'(f.io_imem_req_valid), 32'd1);
    check("rst_inst_valid", 32'(f.io_inst_valid), 32'd0);
    check("rst_stall_rdy1", 32'(f.io_stall_en), 32'd0);
    f.io_imem_req_ready = 1'b0; #1;
    check("rst_stall_rdy0", 32'(f.io_stall_en), 32'd1);
    @(posedge clock); #1;

    // Streaming, 1-cycle memory, decode always ready
    do_reset();
    run(12);
    for (int i = 0; i < 8; i++) check($sformatf("stream_pc%0d", i), dq_pc[i], 32'(4 * i));
    check("stream_data5", dq_data[5], word(32'h14));
    check("stream_first_cyc", 32'(dq_cyc[0]), 32'(2 - BYP));
    check("stream_no_gap", 32'(dq_cyc[7] - dq_cyc[0]), 32'd7);
    check("stream_stalls", 32'(n_stall), 32'd0);

    // Decode blocked: queue fills to DEPTH then holds the PC
    do_reset();
    dec_rdy = 1'b0;
    run(8);
    check("full_nfire", 32'(n_fire), 32'd4);
    check("full_last_addr", last_fire, 32'hC);
    check("full_req_valid", 32'(o_req_valid), 32'd0);
    check("full_stall", 32'(o_stall), 32'd1);
    check("full_pc_held", pc, 32'h10);
    dec_rdy = 1'b1;
    cycle();
    check("full_deq_noreq", 32'(o_req_valid), 32'd0);
    check("full_deq_pc", dq_pc[0], 32'h0);
    cycle();
    check("full_resume_addr", last_fire, 32'h10);
    check("full_resume_nfire", 32'(n_fire), 32'd5);

    // Memory not ready for 3 cycles
    do_reset();
    dec_rdy = 1'b0;
    run(2);
    req_rdy = 1'b0;
    n_stall = 0;
    run(3);
    check("memstall_count", 32'(n_stall), 32'd3);
    check("memstall_pc", pc, 32'h8);
    check("memstall_nfire", 32'(n_fire), 32'd2);
    req_rdy = 1'b1;
    cycle();
    check("memstall_resume", last_fire, 32'h8);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    run(2);
    redir = 1'b1; redir_tgt = 32'h100;
    cycle();
    check("redir_req_blocked", 32'(o_req_valid), 32'd0);
    run(12);
    check("redir_first_pc", dq_pc[0], 32'h100);
    check("redir_first_data", dq_data[0], word(32'h100));
    old_cnt = 0;
    foreach (dq_pc[i]) if (dq_pc[i] < 32'h100) old_cnt++;
    check("redir_no_old", 32'(old_cnt), 32'd0);
    check("redir_max_infl", 32'(max_infl <= 4), 32'd1);

    // Redirect coinciding with a response and a valid head
    do_reset();
    run(4);
    redir = 1'b1; redir_tgt = 32'h200;
    cycle();
    check("rdrsp_inst_valid", 32'(o_inst_valid), 32'd0);
    check("rdrsp_deq_count", 32'(dq_pc.size()), 32'(2 + BYP));
    cycle();
    check("rdrsp_empty_next", 32'(o_inst_valid), 32'd0);
    run(4);
    check("rdrsp_next_pc", dq_pc[2 + BYP], 32'h200);
    check("rdrsp_next_data", dq_data[2 + BYP], word(32'h200));

    // Spurious response into an empty queue is ignored
    do_reset();
    req_rdy = 1'b0;
    spur = 1'b1;
    cycle();
    check("spur_same_cycle", 32'(o_inst_valid), 32'd0);
    cycle();
    check("spur_next_cycle", 32'(o_inst_valid), 32'd0);
    check("spur_no_deq", 32'(dq_pc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
